adc_spi_sampler: RTL
====================

# adc_spi_sampler

Periodic SPI capture engine for the servo's 12-bit position ADC (16-clock frame: 4 leading zeros, then 12 data bits, MSB first). It generates cs/sclk, shifts in sdata, and publishes the sample with a one-cycle strobe. The strobe drives the controller's receive enable and the sample drives its position input. It sits directly upstream of the IPD stage and sets the control-loop sample rate.

## Interface
- cant_bits, 16: width of dato_final (≥12).
- CLK_DIV, 5: clk cycles per sclk half-period (≥2).
- SAMPLE_PERIOD, 100000: clk cycles between conversion starts (≥36*CLK_DIV+2).

- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sdata  input  1  ADC serial data, launched by the ADC on sclk falling edges.
- cs  output  1  ADC chip select, active low.
- sclk  output  1  ADC serial clock, idles high.
- desp_enable_1  output  1  one-cycle new-sample strobe.
- dato_final  output  cant_bits  latest sample, zero-extended 12-bit unsigned value.
- frame_err  output  1  leading-zero check failed on the published sample.

## Operation
- Free-running period counter, 0..SAMPLE_PERIOD-1. tick fires when count = SAMPLE_PERIOD-1.
- FSM states: IDLE, LEAD, SHIFT, TAIL, PUBLISH.
- IDLE: cs=1, sclk=1. On tick: cs←0, go to LEAD.
- LEAD: sclk held high for one half-period (CLK_DIV cycles), then go to SHIFT.
- SHIFT: 16 sclk periods. Each period is a low half-period followed by a high half-period.
  - On the clk edge that drives sclk 0→1, sdata is shifted into a 16-bit register, MSB first.
  - A 5-bit bit counter counts rising edges.
  - After the 16th rising edge, go to TAIL.
- TAIL: sclk high for one half-period, then cs←1 and go to PUBLISH.
- PUBLISH, one cycle:
  - dato_final ← {zeros, shift[11:0]}.
  - frame_err ← |shift[15:12].
  - desp_enable_1 = 1.
  - Go to IDLE.
- A tick that arrives outside IDLE is dropped. The period counter never stops.
- sdata is not resynchronized. It is stable for a full sclk low half-period before sampling.
- Reset, including mid-frame:
  - cs=1, sclk=1, desp_enable_1=0, dato_final=0, frame_err=0.
  - Counters cleared, state IDLE, partial frame discarded.

## Timing
- cs low for exactly 34*CLK_DIV clk cycles per frame.
- sclk period = 2*CLK_DIV clk cycles; exactly 16 falling and 16 rising edges per frame.
- First tick SAMPLE_PERIOD cycles after reset deassertion.
- Latency from tick to strobe: 34*CLK_DIV+1 cycles (registered outputs).
- Strobes spaced exactly SAMPLE_PERIOD cycles apart (averaging off).
- dato_final and frame_err change only in the strobe cycle and hold until the next strobe.

## Configuration
- ADC_AVG_EN defined:
  - Frames are accumulated in a 14-bit sum; frame_err is ORed across frames.
  - After every 4th frame: dato_final ← sum[13:2], frame_err ← ORed flag, strobe once, then clear the accumulator.
  - Strobe spacing becomes 4*SAMPLE_PERIOD; the first strobe follows the 4th frame after reset.
- ADC_AVG_EN undefined: every frame is published as described above. No accumulator logic is present.

## Test plan
- Reset with sdata=1 → cs=1, sclk=1, dato_final=0, frame_err=0, desp_enable_1=0. First cs fall exactly SAMPLE_PERIOD cycles after reset release.
- ADC model serves 16'h0ABC, CLK_DIV=5 → cs low 170 cycles, 16 sclk rising edges, single strobe 171 cycles after tick, dato_final=16'h0ABC, frame_err=0.
- Back-to-back frames 16'h0FFF then 16'h0000 → dato_final 16'h0FFF then 16'h0000; strobes exactly SAMPLE_PERIOD apart.
- Frame 16'hF123 → dato_final=16'h0123, frame_err=1. Next frame 16'h0123 → frame_err=0.
- rst asserted after the 8th sclk rising edge → cs and sclk go high in the same cycle, no strobe, dato_final=0. The next frame after release completes normally.
- ADC_AVG_EN defined, frames 0x100, 0x200, 0x300, 0x404 → no strobe for frames 1–3. One strobe after frame 4 with dato_final=16'h0281.

Source files
------------

// File: rtl/adc_spi_sampler_if.sv
// Bus between the ADC capture engine and its neighbours: SPI pins toward the ADC,
// sample strobe and data toward the controller.
interface adc_spi_sampler_if #(
    parameter int unsigned cant_bits = 16
);
    logic                 cs;
    logic                 sclk;
    logic                 sdata;
    logic                 desp_enable_1;
    logic [cant_bits-1:0] dato_final;
    logic                 frame_err;

    modport master (
        output cs, sclk, desp_enable_1, dato_final, frame_err,
        input  sdata
    );

    modport slave (
        input  cs, sclk, desp_enable_1, dato_final, frame_err,
        output sdata
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic SPI capture of a 12-bit ADC frame (4 leading zeros + 12 data bits, MSB first).
// Define ADC_AVG_EN to publish the average of every 4 frames instead of each frame.
module adc_spi_sampler #(
    parameter int unsigned cant_bits     = 16,
    parameter int unsigned CLK_DIV       = 5,
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    adc_spi_sampler_if.master   bus
);
    localparam int unsigned PC_W       = $clog2(SAMPLE_PERIOD);
    localparam int unsigned HC_W       = $clog2(CLK_DIV);
    localparam int unsigned BC_W       = 5;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned SUM_W      = 14;

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, PUBLISH} state_t;

    state_t               state_q, state_d;
    logic [PC_W-1:0]      pcnt_q, pcnt_d;
    logic [HC_W-1:0]      hcnt_q, hcnt_d;
    logic [BC_W-1:0]      bcnt_q, bcnt_d;
    logic [15:0]          shift_q, shift_d;
    logic                 cs_q, cs_d;
    logic                 sclk_q, sclk_d;
    logic                 strobe_q, strobe_d;
    logic                 err_q, err_d;
    logic [cant_bits-1:0] dato_q, dato_d;
    logic                 tick;
    logic                 half_done;

`ifdef ADC_AVG_EN
    logic [SUM_W-1:0]     sum_q, sum_d, sum_new;
    logic [1:0]           fcnt_q, fcnt_d;
    logic                 acc_err_q, acc_err_d, acc_err_new;
`endif

    assign tick      = (pcnt_q == PC_W'(SAMPLE_PERIOD - 1));
    assign half_done = (hcnt_q == HC_W'(CLK_DIV - 1));
    assign pcnt_d    = tick ? '0 : pcnt_q + PC_W'(1);

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        strobe_d = 1'b0;
        dato_d   = dato_q;
        err_d    = err_q;
`ifdef ADC_AVG_EN
        sum_new     = sum_q + SUM_W'(shift_q[11:0]);
        acc_err_new = acc_err_q | (|shift_q[15:12]);
        sum_d       = sum_q;
        fcnt_d      = fcnt_q;
        acc_err_d   = acc_err_q;
`endif
        case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                hcnt_d = '0;
                bcnt_d = '0;
                if (tick) begin
                    cs_d    = 1'b0;
                    state_d = LEAD;
                end
            end
            LEAD: begin
                if (half_done) begin
                    hcnt_d  = '0;
                    sclk_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            SHIFT: begin
                // Sample on the rising sclk edge; the high half after the last bit belongs to SHIFT.
                if (half_done) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d  = 1'b1;
                        shift_d = {shift_q[14:0], bus.sdata};
                        bcnt_d  = bcnt_q + BC_W'(1);
                    end else if (bcnt_q == BC_W'(FRAME_BITS)) begin
                        state_d = TAIL;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            TAIL: begin
                if (half_done) begin
                    hcnt_d  = '0;
                    cs_d    = 1'b1;
                    state_d = PUBLISH;
                end else begin
                    hcnt_d = hcnt_q + HC_W'(1);
                end
            end
            PUBLISH: begin
                state_d = IDLE;
`ifdef ADC_AVG_EN
                fcnt_d = fcnt_q + 2'd1;
                if (fcnt_q == 2'd3) begin
                    dato_d    = cant_bits'(sum_new >> 2);
                    err_d     = acc_err_new;
                    strobe_d  = 1'b1;
                    sum_d     = '0;
                    acc_err_d = 1'b0;
                end else begin
                    sum_d     = sum_new;
                    acc_err_d = acc_err_new;
                end
`else
                dato_d   = cant_bits'(shift_q[11:0]);
                err_d    = |shift_q[15:12];
                strobe_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            bcnt_q   <= '0;
            shift_q  <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b1;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            dato_q   <= '0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            dato_q   <= dato_d;
        end
    end

`ifdef ADC_AVG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            fcnt_q    <= '0;
            acc_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            fcnt_q    <= fcnt_d;
            acc_err_q <= acc_err_d;
        end
    end
`endif

    assign bus.cs            = cs_q;
    assign bus.sclk          = sclk_q;
    assign bus.desp_enable_1 = strobe_q;
    assign bus.dato_final    = dato_q;
    assign bus.frame_err     = err_q;
endmodule
